// File: rtl/tmds_ddr_serializer.sv
// tmds_ddr_serializer
// Takes one 10-bit TMDS symbol per lane (red/green/blue) plus a fixed clock
// pattern and emits 2 bits per lane per clk_shift cycle. Each output pair is
// meant for a DDR output cell: [0] goes out in the first half-cycle, [1] in
// the second. A full symbol takes 5 cycles, pair 0 first (LSB first).
//
// Handshake (valid/ready): a triple transfers on a rising edge where both
// in_valid and in_ready are high. in_ready is high only in the last-pair
// cycle (phase 4). Upstream must hold in_red/in_green/in_blue stable while
// in_valid is high and in_ready is low; the data are not sampled in any
// other cycle. If no triple is offered when a new symbol is due, the control
// word C_idle_word is sent on the colour lanes instead and one underflow
// is recorded.
//
// dbg_phase mirrors the internal pair counter for observation only.

module tmds_ddr_serializer #(
  parameter logic [9:0] C_clock_word = 10'b0000011111,
  parameter logic [9:0] C_idle_word  = 10'b1101010100
) (
  input  logic        clk_shift,
  input  logic        rst,
  input  logic [9:0]  in_red,
  input  logic [9:0]  in_green,
  input  logic [9:0]  in_blue,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [1:0]  out_clock,
  output logic [1:0]  out_red,
  output logic [1:0]  out_green,
  output logic [1:0]  out_blue,
  output logic        word_start,
  output logic        underflow,
  output logic [15:0] underflow_count,
  output logic [2:0]  dbg_phase
);

  // Pair index currently on the outputs runs 0..4; 4 is the load point.
  localparam logic [2:0]  LAST_PAIR = 3'd4;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  logic [9:0]  sr_clock_q, sr_clock_d;
  logic [9:0]  sr_red_q,   sr_red_d;
  logic [9:0]  sr_green_q, sr_green_d;
  logic [9:0]  sr_blue_q,  sr_blue_d;
  logic [2:0]  phase_q,    phase_d;
  logic        underflow_q, underflow_d;
  logic [15:0] count_q,    count_d;

  logic load_slot;
  logic starve;

  // Handshake and pair-position decode.
  always_comb begin
    load_slot  = (phase_q == LAST_PAIR);
    in_ready   = load_slot & ~rst;
    starve     = load_slot & ~in_valid;
    word_start = (phase_q == 3'd0);
  end

  // Next-state: shift by one pair, or load a fresh symbol on every lane at
  // once so the clock lane can never drift relative to the data lanes.
  always_comb begin
    sr_clock_d  = {2'b00, sr_clock_q[9:2]};
    sr_red_d    = {2'b00, sr_red_q[9:2]};
    sr_green_d  = {2'b00, sr_green_q[9:2]};
    sr_blue_d   = {2'b00, sr_blue_q[9:2]};
    phase_d     = phase_q + 3'd1;
    underflow_d = 1'b0;
    count_d     = count_q;

    if (load_slot) begin
      sr_clock_d = C_clock_word;
      phase_d    = 3'd0;
      if (in_valid) begin
        sr_red_d   = in_red;
        sr_green_d = in_green;
        sr_blue_d  = in_blue;
      end else begin
        sr_red_d    = C_idle_word;
        sr_green_d  = C_idle_word;
        sr_blue_d   = C_idle_word;
        underflow_d = 1'b1;
        if (count_q != COUNT_MAX) begin
          count_d = count_q + 16'd1;
        end
      end
    end else if (phase_q > LAST_PAIR) begin
      // Unreachable encodings fall back to the load point.
      phase_d = LAST_PAIR;
    end
  end

  // State registers; reset abandons any partially sent symbol.
  always_ff @(posedge clk_shift) begin
    if (rst) begin
      sr_clock_q  <= '0;
      sr_red_q    <= '0;
      sr_green_q  <= '0;
      sr_blue_q   <= '0;
      phase_q     <= LAST_PAIR;
      underflow_q <= 1'b0;
      count_q     <= '0;
    end else begin
      sr_clock_q  <= sr_clock_d;
      sr_red_q    <= sr_red_d;
      sr_green_q  <= sr_green_d;
      sr_blue_q   <= sr_blue_d;
      phase_q     <= phase_d;
      underflow_q <= underflow_d;
      count_q     <= count_d;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    out_clock       = sr_clock_q[1:0];
    out_red         = sr_red_q[1:0];
    out_green       = sr_green_q[1:0];
    out_blue        = sr_blue_q[1:0];
    underflow       = underflow_q;
    underflow_count = count_q;
    dbg_phase       = phase_q;
  end

endmodule

// File: tb/tb_tmds_ddr_serializer.sv
// tb_tmds_ddr_serializer
// Directed sequence in one initial block. Each tick checks the outputs of
// the current cycle against a queue of expected pairs, then drives inputs
// for the next edge and pushes the five pairs of any symbol due to load.

module tb_tmds_ddr_serializer;

  localparam logic [9:0] CLK_WORD  = 10'b0000011111;
  localparam logic [9:0] IDLE_WORD = 10'b1101010100;

  // ---------------- clock / reset ----------------
  logic clk_shift = 1'b0;
  always #5 clk_shift = ~clk_shift;

  logic        rst;
  logic [9:0]  in_red, in_green, in_blue;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  out_clock, out_red, out_green, out_blue;
  logic        word_start, underflow;
  logic [15:0] underflow_count;
  logic [2:0]  dbg_phase;

  tmds_ddr_serializer dut (
    .clk_shift       (clk_shift),
    .rst             (rst),
    .in_red          (in_red),
    .in_green        (in_green),
    .in_blue         (in_blue),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_clock       (out_clock),
    .out_red         (out_red),
    .out_green       (out_green),
    .out_blue        (out_blue),
    .word_start      (word_start),
    .underflow       (underflow),
    .underflow_count (underflow_count),
    .dbg_phase       (dbg_phase)
  );

  // ---------------- scoreboard ----------------
  // entry = {clock, red, green, blue, word_start, underflow}
  logic [9:0] exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         m_phase     = 4;
  logic [15:0] m_count    = '0;
  int         n_uf_pulses = 0;

  function automatic logic [1:0] pair_of(input logic [9:0] w, input int k);
    logic [9:0] t;
    t = w;
    return {t[2*k+1], t[2*k]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_symbol(input logic [9:0] r, input logic [9:0] g,
                             input logic [9:0] b, input logic idle);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({pair_of(CLK_WORD, k), pair_of(r, k), pair_of(g, k),
                       pair_of(b, k), (k == 0), (idle && k == 0)});
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic rs, input logic v,
                      input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    logic [9:0] e;
    @(negedge clk_shift);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'd0;
    check("lanes", {out_clock, out_red, out_green, out_blue, word_start, underflow}, e);
    check("underflow_count", underflow_count, m_count);
    check("phase", dbg_phase, m_phase[2:0]);
    if (underflow) n_uf_pulses++;
    rst = rs; in_valid = v; in_red = r; in_green = g; in_blue = b;
    #1;
    check("in_ready", in_ready, (m_phase == 4) && !rs);
    if (rs) begin
      exp_q.delete();
      m_phase = 4;
      m_count = '0;
    end else if (m_phase == 4) begin
      if (v) push_symbol(r, g, b, 1'b0);
      else begin
        push_symbol(IDLE_WORD, IDLE_WORD, IDLE_WORD, 1'b1);
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end
  endtask

  function automatic logic [9:0] rnd();
    return 10'($urandom_range(0, 1023));
  endfunction

  logic [9:0] sym [4];
  logic [9:0] data_a, data_b;
  int idx, guard;

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_red = '0; in_green = '0; in_blue = '0;
    repeat (2) @(posedge clk_shift);

    // Reset state
    repeat (3) tick(1'b1, 1'b0, rnd(), rnd(), rnd());

    // Single symbol at first ready cycle, then idle fill
    tick(1'b0, 1'b1, 10'b1010011100, 10'b0110100101, 10'b1111100000);
    repeat (4) tick(1'b0, 1'b0, rnd(), rnd(), rnd());

    // Back-to-back: valid held, data advances only after acceptance
    for (int i = 0; i < 4; i++) sym[i] = rnd();
    idx = 0;
    guard = 0;
    while (idx < 4 && guard < 40) begin
      tick(1'b0, 1'b1, sym[idx], ~sym[idx], sym[idx] ^ 10'h155);
      if (m_phase == 0) idx++;
      guard++;
    end
    check("b2b_accepts", idx, 4);
    while (m_phase != 4) tick(1'b0, 1'b1, sym[3], ~sym[3], sym[3] ^ 10'h155);
    check("b2b_count", underflow_count, 16'd0);

    // Starvation: three idle symbol periods
    n_uf_pulses = 0;
    repeat (15) tick(1'b0, 1'b0, rnd(), rnd(), rnd());
    repeat (1) tick(1'b0, 1'b1, 10'h2AA, 10'h155, 10'h3C3);
    check("starve_pulses", n_uf_pulses, 3);
    check("starve_count", underflow_count, 16'd3);

    // Backpressure: A offered at phase 1, replaced by B at phase 2
    data_a = 10'h0F0; data_b = 10'h30F;
    guard = 0;
    while (m_phase != 1 && guard < 10) begin
      tick(1'b0, 1'b0, rnd(), rnd(), rnd());
      guard++;
    end
    tick(1'b0, 1'b1, data_a, data_a, data_a);
    repeat (3) tick(1'b0, 1'b1, data_b, data_b, data_b);
    repeat (5) tick(1'b0, 1'b0, rnd(), rnd(), rnd());

    // Reset mid-symbol at phase 2
    guard = 0;
    while (m_phase != 2 && guard < 10) begin
      tick(1'b0, 1'b1, 10'h1E5, 10'h21A, 10'h0C3);
      guard++;
    end
    tick(1'b1, 1'b0, rnd(), rnd(), rnd());
    tick(1'b1, 1'b0, rnd(), rnd(), rnd());
    tick(1'b0, 1'b1, 10'h3A5, 10'h05A, 10'h2F0);
    repeat (5) tick(1'b0, 1'b0, rnd(), rnd(), rnd());

    // Saturation: preload counter near the top, then starve
    guard = 0;
    while (m_phase != 2 && guard < 10) begin
      tick(1'b0, 1'b0, rnd(), rnd(), rnd());
      guard++;
    end
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    m_count = 16'hFFFE;
    n_uf_pulses = 0;
    repeat (18) tick(1'b0, 1'b0, rnd(), rnd(), rnd());
    check("sat_count", underflow_count, 16'hFFFF);
    check("sat_pulses", n_uf_pulses, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
